// File: rtl/icache_data_array.sv
`default_nettype none
// ============================================================================
// Module      : icache_data_array
// Description : Multi-way instruction-cache data store. Reads the addressed
//               word from every way in parallel with one cycle of latency and
//               runs a critical-word-first line refill from the AXI read
//               channel, with write-first bypass on read/refill collisions.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_data_array #(
    parameter  int WAYS       = 2,
    parameter  int SETS       = 128,
    parameter  int LINE_WORDS = 8,
    parameter  int DATA_W     = 32,
    localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int IDX_W      = $clog2(SETS),
    localparam int OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   rd_en,
    input  logic [IDX_W-1:0]       rd_index,
    input  logic [OFF_W-1:0]       rd_offset,
    output logic                   rd_valid,
    output logic [WAYS*DATA_W-1:0] rd_data,
    input  logic                   fill_start,
    input  logic [WAY_W-1:0]       fill_way,
    input  logic [IDX_W-1:0]       fill_index,
    input  logic [OFF_W-1:0]       fill_offset,
    input  logic                   fill_valid,
    input  logic [DATA_W-1:0]      fill_data,
    output logic                   fill_busy,
    output logic                   fill_done
);

    localparam int ADDR_W = IDX_W + OFF_W;
    localparam int DEPTH  = SETS * LINE_WORDS;

    localparam logic [0:0]       c_IDLE = 1'b0;
    localparam logic [0:0]       c_FILL = 1'b1;
    localparam logic [OFF_W-1:0] c_LAST = OFF_W'(LINE_WORDS - 1);

    logic [0:0]       r_state;
    logic [WAY_W-1:0] r_way;
    logic [IDX_W-1:0] r_index;
    logic [OFF_W-1:0] r_ptr;
    logic [OFF_W-1:0] r_cnt;
    logic             r_done;
    logic             r_rd_valid;

    logic              w_wr;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [ADDR_W-1:0] w_rd_addr;

    // A beat is only consumed while a refill is in progress.
    assign w_wr      = (r_state == c_FILL) && fill_valid;
    assign w_wr_addr = {r_index, r_ptr};
    assign w_rd_addr = {rd_index, rd_offset};

    assign fill_busy = (r_state == c_FILL);
    assign fill_done = r_done;
    assign rd_valid  = r_rd_valid;

    // Refill sequencer: latch target line, walk the wrapping word pointer,
    // and leave after LINE_WORDS accepted beats.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_IDLE;
            r_way   <= '0;
            r_index <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (fill_start) begin
                        r_state <= c_FILL;
                        r_way   <= fill_way;
                        r_index <= fill_index;
                        r_ptr   <= fill_offset;
                        r_cnt   <= '0;
                    end
                end
                c_FILL: begin
                    if (fill_valid) begin
                        r_ptr <= r_ptr + 1'b1;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_LAST) begin
                            r_state <= c_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Read-valid tracks the previous cycle's request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
        end
    end

    generate
        for (genvar w = 0; w < WAYS; w++) begin : g_way
            logic [DATA_W-1:0] r_mem [DEPTH];
            logic [DATA_W-1:0] r_lane;
            logic              w_wr_way;
            logic              w_hit;

            assign w_wr_way = w_wr && (r_way == WAY_W'(w));
            assign w_hit    = w_wr_way && (w_wr_addr == w_rd_addr);
            assign rd_data[w*DATA_W +: DATA_W] = r_lane;

            // Line storage; contents deliberately left unreset.
            always_ff @(posedge clk) begin
                if (w_wr_way) begin
                    r_mem[w_wr_addr] <= fill_data;
                end
            end

            // Read lane: write-first so a same-cycle refill beat is visible.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_lane <= '0;
                end else if (rd_en) begin
                    r_lane <= w_hit ? fill_data : r_mem[w_rd_addr];
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/icache_data_array.md
# icache_data_array

Parametrised multi-way instruction-cache data store for the myCPU icache. It replaces the single-port per-way data RAM wrapper with one block that holds all ways and serves a one-cycle-latency read of the addressed word from every way in parallel. It also runs a line refill from the AXI read channel with critical-word-first wrap-around and a write-first bypass. It sits between the icache tag/control FSM (which drives reads, way selection and refill start) and the AXI refill path (which supplies beats).

## Interface
Parameters:
- WAYS, 2: number of ways (power of two, ≥1); WAY_W = max(1, log2(WAYS)).
- SETS, 128: lines per way (power of two); IDX_W = log2(SETS).
- LINE_WORDS, 8: words per line (power of two, ≥2); OFF_W = log2(LINE_WORDS).
- DATA_W, 32: word width.

Ports:
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- rd_en  in  1  read request, sampled each cycle.
- rd_index  in  IDX_W  set index of read.
- rd_offset  in  OFF_W  word offset of read.
- rd_valid  out  1  rd_data holds the result of the previous cycle's rd_en.
- rd_data  out  WAYS*DATA_W  way w at [w*DATA_W +: DATA_W].
- fill_start  in  1  begin refill of one line.
- fill_way  in  WAY_W  victim way, sampled with fill_start.
- fill_index  in  IDX_W  line index, sampled with fill_start.
- fill_offset  in  OFF_W  first (critical) word offset, sampled with fill_start.
- fill_valid  in  1  refill beat present on fill_data.
- fill_data  in  DATA_W  refill beat.
- fill_busy  out  1  refill in progress.
- fill_done  out  1  one-cycle pulse after the last beat is written.

## Operation
- Storage: WAYS × SETS × LINE_WORDS words of DATA_W in behavioural arrays. Contents are not reset.
- FSM has two states, IDLE and FILL.
  - IDLE: fill_start=1 moves to FILL and latches way, index, ptr=fill_offset and beat count cnt=0. fill_valid is ignored in IDLE, including the cycle of fill_start.
  - FILL: each fill_valid=1 writes fill_data to [way][index][ptr]. ptr then advances by 1 modulo LINE_WORDS (wraps LINE_WORDS-1→0) and cnt increments. fill_start is ignored.
  - When fill_valid=1 with cnt==LINE_WORDS-1, the FSM returns to IDLE.
- fill_busy is registered and equals state==FILL.
- fill_done is registered and is 1 for exactly the cycle after the last beat write.
- Read behaviour:
  - rd_en=1 samples rd_index/rd_offset. On the next cycle rd_valid=1 and rd_data carries the word at [index][offset] for every way.
  - When rd_en=0, rd_valid=0 next cycle and rd_data holds its last value.
- Reads are accepted in both states at full rate. No stall or backpressure exists.
- Write-first collision: if a fill write lands in the same cycle as rd_en with equal index and offset, the lane for the fill way returns fill_data. Other lanes return stored data.
- Reset mid-fill returns the FSM to IDLE with no fill_done. The partially written line stays in the array, and the icache control FSM must keep its tag invalid.

## Timing
- Reset values: state IDLE, rd_valid=0, rd_data=0, fill_busy=0, fill_done=0, ptr=0, cnt=0.
- Read latency is 1 cycle, throughput 1 per cycle.
- Refill:
  - fill_start at cycle T; fill_busy=1 from T+1.
  - The first beat is accepted no earlier than T+1, at up to 1 beat per cycle. Gaps in fill_valid are allowed.
  - A last beat at cycle L gives fill_busy=0 and fill_done=1 at L+1.
  - fill_start at L+1 is accepted, so back-to-back refills are possible.
- A line refill written at cycle t is readable by rd_en at t+1, and at t via the bypass.

## Test plan
- Reset, then read index 0 offset 0 → rd_valid=0 until one cycle after rd_en, rd_data=0 during reset; fill_busy=0, fill_done=0.
- fill_start way1 index 5 offset 6, then 8 consecutive beats 0xA0..0xA7 → words 6,7,0..5 hold 0xA0,0xA1,0xA2..0xA7. fill_done pulses once on the cycle after beat 0xA7. Reading way1 lane at index 5 offset 0 returns 0xA2, while the way0 lane is unchanged.
- Same refill with fill_valid toggling 1,0,1,0 → identical final contents; fill_busy stays high across the gaps.
- rd_en index 5 offset 7 in the same cycle as the beat writing 0xA1 to way1 offset 7 → next cycle the way1 lane is 0xA1 and the way0 lane holds its old value.
- fill_start pulsed again mid-fill and fill_valid pulsed while IDLE → both ignored; contents and beat count are unaffected.
- resetn asserted after 3 of 8 beats → fill_busy=0 immediately, no fill_done. A new fill_start after reset completes normally with 8 beats.
